// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Provides the FSM state encoding and the bit-counter width helper.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHIFT,
        FINAL,
        DONE
    } mult_state_t;

    localparam int MIN_WIDTH = 2;

    // Counter must index 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_addsub_n.sv
// Combinational (WIDTH+1)-bit add/subtract of the running {X,A} and an addend.
// Ports: a, b (WIDTH+1) operands; sub selects a-b; sum (WIDTH+1); carry_out.
module mult_addsub_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           carry_out
);

    logic [WIDTH:0]   b_eff;
    logic [WIDTH+1:0] full;

    // Subtraction as a + ~b + 1.
    assign b_eff     = sub ? ~b : b;
    assign full      = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, sub};
    assign sum       = full[WIDTH:0];
    assign carry_out = full[WIDTH+1];

endmodule

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, signed/unsigned, with optional accumulate.
// Ports: Clk, Reset (async high), Start, Signed_Mode, Acc_Mode, Clear,
//        Multiplicand, Multiplier -> Busy, Done, Product (2*WIDTH), Xval.
module seq_multiplier_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed_Mode,
    input  logic                 Acc_Mode,
    input  logic                 Clear,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Xval
);

    localparam int CW = cnt_width(WIDTH);

    mult_state_t      state;
    logic             x;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic             sgn;
    logic             acc;

    logic             last;
    logic             sub;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             addsub_cout_unused;
    logic [2*WIDTH-1:0] prod_acc;

    assign last     = (cnt == CW'(WIDTH - 1));
    // Signed: sign-extend M, subtract on the sign-bit step of B.
    assign addend   = sgn ? {m[WIDTH-1], m} : {1'b0, m};
    assign sub      = sgn & last;
    assign prod_acc = Product + {a, b};
    assign Xval     = x;

    mult_addsub_n #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a        ({x, a}),
        .b        (addend),
        .sub      (sub),
        .sum      (sum),
        .carry_out(addsub_cout_unused)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            x       <= 1'b0;
            a       <= '0;
            b       <= '0;
            m       <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            acc     <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        m     <= Multiplicand;
                        b     <= Multiplier;
                        x     <= 1'b0;
                        a     <= '0;
                        cnt   <= '0;
                        sgn   <= Signed_Mode;
                        acc   <= Acc_Mode;
                        Busy  <= 1'b1;
                        state <= ADD;
                    end else if (Clear) begin
                        Product <= '0;
                    end
                end
                ADD: begin
                    // In unsigned mode X is 0 here, so sum[WIDTH] is A+M carry.
                    if (b[0]) begin
                        {x, a} <= sum;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // X feeds A's MSB; it is kept only for arithmetic shift.
                    {x, a, b} <= {sgn & x, x, a, b[WIDTH-1:1]};
                    cnt       <= cnt + CW'(1);
                    state     <= last ? FINAL : ADD;
                end
                FINAL: begin
                    Product <= acc ? prod_acc : {a, b};
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Scoreboard bench for seq_multiplier_n at WIDTH=8 and WIDTH=16.
// Directed vectors push expectations; negedge monitors pop on Done.
module tb_seq_multiplier_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sm;
    logic        am;
    logic        clr;
    logic        st8;
    logic        st16;
    logic [7:0]  mc8;
    logic [7:0]  mp8;
    logic [15:0] mc16;
    logic [15:0] mp16;

    logic        busy8;
    logic        done8;
    logic        x8;
    logic [15:0] p8;
    logic        busy16;
    logic        done16;
    logic        x16;
    logic [31:0] p16;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int dn8  = 0;
    int dn16 = 0;
    int bc8  = 0;
    int bc16 = 0;

    typedef struct {
        logic [31:0] p;
        int          t;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    seq_multiplier_n #(.WIDTH(8)) dut8 (
        .Clk         (clk),
        .Reset       (rst),
        .Start       (st8),
        .Signed_Mode (sm),
        .Acc_Mode    (am),
        .Clear       (clr),
        .Multiplicand(mc8),
        .Multiplier  (mp8),
        .Busy        (busy8),
        .Done        (done8),
        .Product     (p8),
        .Xval        (x8)
    );

    seq_multiplier_n #(.WIDTH(16)) dut16 (
        .Clk         (clk),
        .Reset       (rst),
        .Start       (st16),
        .Signed_Mode (sm),
        .Acc_Mode    (am),
        .Clear       (clr),
        .Multiplicand(mc16),
        .Multiplier  (mp16),
        .Busy        (busy16),
        .Done        (done16),
        .Product     (p16),
        .Xval        (x16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst) begin
            bc8 = 0;
        end else begin
            if (busy8) bc8++;
            if (done8) begin
                dn8++;
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("product8", {16'h0, p8}, e.p);
                    chk("latency8", cyc - e.t, 32'd17);
                    chk("busy_len8", bc8, 32'd17);
                end
                bc8 = 0;
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst) begin
            bc16 = 0;
        end else begin
            if (busy16) bc16++;
            if (done16) begin
                dn16++;
                if (q16.size() == 0) begin
                    chk("unexpected_done16", 32'd1, 32'd0);
                end else begin
                    e = q16.pop_front();
                    chk("product16", p16, e.p);
                    chk("latency16", cyc - e.t, 32'd33);
                    chk("busy_len16", bc16, 32'd33);
                end
                bc16 = 0;
            end
        end
    end

    task automatic issue(input bit w16, input bit s, input bit a,
                         input bit c, input logic [15:0] x,
                         input logic [15:0] y, input logic [31:0] e,
                         input bit push);
        exp_t ent;
        @(negedge clk);
        sm  = s;
        am  = a;
        clr = c;
        if (w16) begin
            mc16 = x;
            mp16 = y;
            st16 = 1'b1;
        end else begin
            mc8 = x[7:0];
            mp8 = y[7:0];
            st8 = 1'b1;
        end
        @(posedge clk);
        #1;
        st8  = 1'b0;
        st16 = 1'b0;
        clr  = 1'b0;
        ent.p = e;
        ent.t = cyc;
        if (push) begin
            if (w16) q16.push_back(ent);
            else     q8.push_back(ent);
        end
    endtask

    task automatic wait_done(input bit w16, input int budget);
        int c0;
        bit got;
        c0  = w16 ? dn16 : dn8;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #2;
            if ((w16 ? dn16 : dn8) != c0) got = 1'b1;
        end
        chk(w16 ? "done_wait16" : "done_wait8", {31'd0, got}, 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        sm   = 1'b0;
        am   = 1'b0;
        clr  = 1'b0;
        st8  = 1'b0;
        st16 = 1'b0;
        mc8  = '0;
        mp8  = '0;
        mc16 = '0;
        mp16 = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_prod", {16'd0, p8}, 32'd0);
        chk("rst_xval", {31'd0, x8}, 32'd0);
        chk("rst_prod16", p16, 32'd0);
        rst = 1'b0;

        // Unsigned full-scale
        issue(0, 0, 0, 0, 16'hFF, 16'hFF, 32'hFE01, 1);
        wait_done(0, 40);

        // Signed cases
        issue(0, 1, 0, 0, 16'h80, 16'h80, 32'h4000, 1);
        wait_done(0, 40);
        issue(0, 1, 0, 0, 16'h07, 16'hFD, 32'hFFEB, 1);
        wait_done(0, 40);
        issue(0, 1, 0, 0, 16'hFF, 16'h01, 32'hFFFF, 1);
        wait_done(0, 40);

        // Clear, then accumulate chain
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clear_prod", {16'd0, p8}, 32'd0);
        issue(0, 0, 0, 0, 16'd3, 16'd4, 32'd12, 1);
        wait_done(0, 40);
        issue(0, 0, 1, 0, 16'd5, 16'd6, 32'd42, 1);
        wait_done(0, 40);
        issue(0, 0, 1, 0, 16'hFF, 16'hFF, 32'hFE2B, 1);
        wait_done(0, 40);

        // Start pulse and operand changes while busy are ignored
        issue(0, 0, 0, 0, 16'd10, 16'd10, 32'd100, 1);
        repeat (3) @(negedge clk);
        mc8 = 8'd77;
        mp8 = 8'd3;
        am  = 1'b1;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        wait_done(0, 40);
        repeat (3) @(negedge clk);
        chk("hold_prod", {16'd0, p8}, 32'd100);
        chk("no_restart", {31'd0, busy8}, 32'd0);

        // Clear together with Start: start wins, accumulate over 100
        issue(0, 0, 1, 1, 16'd3, 16'd3, 32'd109, 1);
        wait_done(0, 40);

        // Reset in the middle of an operation
        issue(0, 0, 0, 0, 16'd9, 16'd9, 32'd0, 0);
        repeat (4) @(negedge clk);
        chk("mid_busy", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_prod", {16'd0, p8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 0, 0, 0, 16'd2, 16'd3, 32'd6, 1);
        wait_done(0, 40);

        // 16-bit signed extreme
        issue(1, 1, 0, 0, 16'h8000, 16'h7FFF, 32'hC0008000, 1);
        wait_done(1, 60);

        repeat (2) @(negedge clk);
        chk("q8_drained", q8.size(), 32'd0);
        chk("q16_drained", q16.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
